csr_exec: RTL

//   Initiator side of the CSR read/write port. Executes one Zicsr instruction
//   (CSRRW/CSRRS/CSRRC and their immediate forms) as a sequenced read-modify-write

---
 rtl/csr_exec.sv | 116 +++++++++++
 1 files changed

// File: rtl/csr_exec.sv
// ============================================================================
// Module  : csr_exec
// Brief   : Sequences one Zicsr instruction as a read-modify-write on the
//           csrfile port and returns the old CSR value for rd writeback.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module csr_exec #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_csr_addr,
    input  logic [XLEN-1:0]   i_rs1_data,
    input  logic [4:0]        i_zimm,
    input  logic              i_rd_nz,
    input  logic              i_flush,
    output logic              o_csr_ren,
    output logic [ADDR_W-1:0] o_csr_addr,
    output logic              o_csr_wen,
    output logic [XLEN-1:0]   o_csr_wdata,
    input  logic [XLEN-1:0]   i_csr_rdata,
    output logic              o_done,
    output logic              o_illegal,
    output logic              o_rd_wen,
    output logic [XLEN-1:0]   o_rd_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [1:0]        kind_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   op_q;
    logic [XLEN-1:0]   rdata_q;
    logic              rd_nz_q;
    logic              wr_en_q;
    logic              illegal_q;

    logic              do_read;
    logic [XLEN-1:0]   wdata;

    // Plain swaps with rd=x0 skip the read so read side effects never fire.
    assign do_read = !((kind_q == 2'b01) && !rd_nz_q);

    always_comb begin
        wdata = op_q;
        case (kind_q)
            2'b10:   wdata = rdata_q | op_q;
            2'b11:   wdata = rdata_q & ~op_q;
            default: wdata = op_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            kind_q    <= 2'b00;
            addr_q    <= '0;
            op_q      <= '0;
            rdata_q   <= '0;
            rd_nz_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && !i_flush) begin
                        kind_q    <= i_funct3[1:0];
                        addr_q    <= i_csr_addr;
                        op_q      <= i_funct3[2] ? {{(XLEN-5){1'b0}}, i_zimm} : i_rs1_data;
                        rd_nz_q   <= i_rd_nz;
                        wr_en_q   <= (i_funct3[1:0] == 2'b01) ? 1'b1 : (i_zimm != 5'd0);
                        illegal_q <= (i_funct3[1:0] == 2'b00);
                        rdata_q   <= '0;
                        state     <= (i_funct3[1:0] == 2'b00) ? DONE : READ;
                    end
                end
                READ: begin
                    if (i_flush) begin
                        state <= IDLE;
                    end else begin
                        rdata_q <= do_read ? i_csr_rdata : '0;
                        state   <= WRITE;
                    end
                end
                WRITE:   state <= i_flush ? IDLE : DONE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once.
    assign o_ready     = (state == IDLE);
    assign o_csr_addr  = (state != IDLE) ? addr_q : '0;
    assign o_csr_ren   = (state == READ) && do_read;
    assign o_csr_wen   = (state == WRITE) && wr_en_q && !i_flush;
    assign o_csr_wdata = (state == WRITE) ? wdata : '0;
    assign o_done      = (state == DONE) && !i_flush;
    assign o_illegal   = o_done && illegal_q;
    assign o_rd_wen    = o_done && rd_nz_q && !illegal_q;
    assign o_rd_data   = o_done ? rdata_q : '0;

endmodule

`default_nettype wire
